// File: rtl/aes_mix_pkg.sv
// Shared types, FSM encoding and GF(2^8) helpers for the MixColumns engine.
package aes_mix_pkg;

  localparam int AES_NCOL = 4;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // 9 = 8 + 1
  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  // 0b = 8 + 2 + 1
  function automatic logic [7:0] gmulb(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  // 0d = 8 + 4 + 1
  function automatic logic [7:0] gmuld(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  // 0e = 8 + 4 + 2
  function automatic logic [7:0] gmule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_mix_column_unit.sv
// Combinational single-column mixer: forward or inverse MixColumns on 32 bits.
module aes_mix_column_unit
  import aes_mix_pkg::*;
(
  input  col_t in,
  input  logic inv,
  output col_t out
);

  logic [7:0] a   [4];
  logic [7:0] fwd [4];
  logic [7:0] bwd [4];
  logic [7:0] res [4];

  // Byte r of the column sits at [31-8r -: 8]; each output byte uses the
  // coefficient row rotated by its own index.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign a[gi]   = in[31-8*gi -: 8];
      assign fwd[gi] = gmul2(a[gi]) ^ gmul3(a[(gi+1)%4]) ^ a[(gi+2)%4] ^ a[(gi+3)%4];
      assign bwd[gi] = gmule(a[gi]) ^ gmulb(a[(gi+1)%4]) ^ gmuld(a[(gi+2)%4]) ^ gmul9(a[(gi+3)%4]);
      assign res[gi] = inv ? bwd[gi] : fwd[gi];
    end
  endgenerate

  assign out = {res[0], res[1], res[2], res[3]};

endmodule

// File: rtl/aes_mix_columns_engine.sv
// Time-multiplexed MixColumns / InvMixColumns / bypass engine with a
// valid/ready block interface. COLS column units process one column group
// per cycle; the result is presented from a dedicated output register.
module aes_mix_columns_engine
  import aes_mix_pkg::*;
#(
  parameter int COLS = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
  input  logic   in_inv,
  input  logic   in_bypass,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state
);

  localparam int NCYC = AES_NCOL / COLS;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] GRP_LAST = CW'(NCYC - 1);

  generate
    if (COLS != 1 && COLS != 2 && COLS != 4) begin : g_bad_cols
      $error("aes_mix_columns_engine: COLS must be 1, 2 or 4");
    end
  endgenerate

  fsm_state_t    state_reg, state_next;
  logic [CW-1:0] grp_reg, grp_next;
  state_t        work_reg, work_next;
  logic          inv_reg, inv_next;
  logic          out_valid_reg, out_valid_next;
  state_t        out_state_reg, out_state_next;

  col_t       work_col [AES_NCOL];
  col_t       mix_col  [AES_NCOL];
  col_t       unit_in  [COLS];
  col_t       unit_out [COLS];
  logic [1:0] unit_sel [COLS];
  state_t     mixed_state;

  // Column view of the working register (column 0 in the top word).
  generate
    for (genvar gi = 0; gi < AES_NCOL; gi++) begin : g_unpack
      assign work_col[gi] = work_reg[127-32*gi -: 32];
    end
  endgenerate

  // Unit gi works on column grp*COLS+gi of the current group.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_unit
      assign unit_sel[gi] = 2'(int'(grp_reg) * COLS + gi);
      assign unit_in[gi]  = work_col[unit_sel[gi]];
      aes_mix_column_unit u_col (
        .in  (unit_in[gi]),
        .inv (inv_reg),
        .out (unit_out[gi])
      );
    end
  endgenerate

  // Merge the freshly mixed group back into the untouched columns.
  always_comb begin
    for (int i = 0; i < AES_NCOL; i++) mix_col[i] = work_col[i];
    for (int u = 0; u < COLS; u++) mix_col[unit_sel[u]] = unit_out[u];
  end

  assign mixed_state = {mix_col[0], mix_col[1], mix_col[2], mix_col[3]};

  // Next-state logic. DONE spends its first cycle copying the working
  // register into the output register; out_valid then rises and both
  // outputs stay frozen until the handshake, independent of the datapath.
  always_comb begin
    state_next     = state_reg;
    grp_next       = grp_reg;
    work_next      = work_reg;
    inv_next       = inv_reg;
    out_valid_next = out_valid_reg;
    out_state_next = out_state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          work_next  = in_state;
          inv_next   = in_inv;
          grp_next   = '0;
          state_next = in_bypass ? DONE : BUSY;
        end
      end
      BUSY: begin
        work_next = mixed_state;
        if (grp_reg == GRP_LAST) begin
          grp_next   = '0;
          state_next = DONE;
        end else begin
          grp_next = grp_reg + 1'b1;
        end
      end
      DONE: begin
        if (!out_valid_reg) begin
          out_valid_next = 1'b1;
          out_state_next = work_reg;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grp_reg       <= '0;
      work_reg      <= '0;
      inv_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_state_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grp_reg       <= grp_next;
      work_reg      <= work_next;
      inv_reg       <= inv_next;
      out_valid_reg <= out_valid_next;
      out_state_reg <= out_state_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_state = out_state_reg;

endmodule

// File: tb/tb_aes_mix_columns_engine.sv
// Directed and randomised checks of the MixColumns engine at COLS=1 and COLS=4.
module tb_aes_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst       [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         in_inv    [2];
  logic         in_bypass [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] in_state  [2];
  logic [127:0] out_state [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Index 0: COLS=1 (latency 5); index 1: COLS=4 (latency 2).
  aes_mix_columns_engine #(.COLS(1)) dut_c1 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_inv(in_inv[0]), .in_bypass(in_bypass[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0])
  );

  aes_mix_columns_engine #(.COLS(4)) dut_c4 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_inv(in_inv[1]), .in_bypass(in_bypass[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1])
  );

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hdb135345_2d26314c_d4d4d4d5_f20a225c;
  localparam logic [127:0] E2 = 128'h8e4da1bc_4d7ebdf8_d5d5d7d6_9fdc589d;
  localparam logic [127:0] V3 = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [127:0] E3 = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
  localparam logic [127:0] VB = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  // Reference: generic shift-and-add GF(2^8) multiply with 0x11B reduction.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] st, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   o;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = st[127 - 32*c - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        o = '0;
        for (int j = 0; j < 4; j++) o = o ^ gf_mul(coef[(j - r + 4) % 4], a[j]);
        res[127 - 32*c - 8*r -: 8] = o;
      end
    end
    return res;
  endfunction

  // Offer one block, keep in_valid high with scrambled data while busy
  // (must be ignored), measure latency, hold out_ready low for 'hold'
  // cycles, then complete the handshake.
  task automatic run_block(input int d, input logic [127:0] st, input logic inv,
                           input logic byp, input logic [127:0] exp_st,
                           input int exp_lat, input int hold, input string name,
                           output logic [127:0] got);
    int           lat;
    logic         rdy_seen;
    logic         stable;
    logic [127:0] held;
    n_vec++;
    if (in_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_ready: got %b want 1", name, in_ready[d]);
    end
    in_state[d] = st; in_inv[d] = inv; in_bypass[d] = byp; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_state[d] = st ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
    in_inv[d] = ~inv; in_bypass[d] = ~byp;
    rdy_seen = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid[d] === 1'b1) break;
      if (in_ready[d] !== 1'b0) rdy_seen = 1'b1;
    end
    in_valid[d] = 1'b0;
    got = out_state[d];
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (got !== exp_st) begin
      n_err++;
      $display("FAIL %s out_state: got %h want %h", name, got, exp_st);
    end
    n_vec++;
    if (rdy_seen !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_ready: got high want low", name);
    end
    held = got;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid[d] !== 1'b1 || out_state[d] !== held || in_ready[d] !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) begin
      n_vec++;
      if (stable !== 1'b1) begin
        n_err++;
        $display("FAIL %s hold_stable: got unstable want stable over %0d cycles", name, hold);
      end
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    n_vec++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: got valid=%b ready=%b want valid=0 ready=1",
               name, out_valid[d], in_ready[d]);
    end
    $display("blk %s dut%0d inv=%b byp=%b lat=%0d out=%h", name, d, inv, byp, lat, got);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; in_inv[d] = 1'b0; in_bypass[d] = 1'b0;
      out_ready[d] = 1'b0; in_state[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (in_ready[d] !== 1'b1) begin
        n_err++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready[d]);
      end
      n_vec++;
      if (out_valid[d] !== 1'b0) begin
        n_err++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid[d]);
      end
      n_vec++;
      if (out_state[d] !== 128'h0) begin
        n_err++; $display("FAIL reset_out_state dut%0d: got %h want 0", d, out_state[d]);
      end
      $display("rst dut%0d ready=%b valid=%b", d, in_ready[d], out_valid[d]);
    end
  endtask

  task automatic test_forward();
    logic [127:0] got;
    run_block(0, V1, 1'b0, 1'b0, E1, 5, 0, "fwd_c1_v1", got);
    run_block(0, V2, 1'b0, 1'b0, E2, 5, 0, "fwd_c1_v2", got);
    run_block(1, V3, 1'b0, 1'b0, E3, 2, 0, "fwd_c4_v3", got);
  endtask

  task automatic test_inverse();
    logic [127:0] got;
    run_block(1, E1, 1'b1, 1'b0, V1, 2, 0, "inv_c4_e1", got);
    run_block(1, E3, 1'b1, 1'b0, V3, 2, 0, "inv_c4_e3", got);
    run_block(0, E2, 1'b1, 1'b0, V2, 5, 0, "inv_c1_e2", got);
  endtask

  task automatic test_bypass();
    logic [127:0] got;
    run_block(0, VB, 1'b1, 1'b1, VB, 1, 0, "byp_c1", got);
    run_block(1, VB, 1'b1, 1'b1, VB, 1, 0, "byp_c4", got);
  endtask

  task automatic test_backpressure();
    logic [127:0] got;
    run_block(0, V2, 1'b0, 1'b0, E2, 5, 10, "bp_c1", got);
    run_block(1, E2, 1'b1, 1'b0, V2, 2, 10, "bp_c4", got);
  endtask

  task automatic test_reset_busy();
    logic         seen;
    logic [127:0] got;
    in_state[0] = V1; in_inv[0] = 1'b0; in_bypass[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    n_vec++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_state[0] !== 128'h0) begin
      n_err++;
      $display("FAIL rst_busy_state: got ready=%b valid=%b out=%h want 1 0 0",
               in_ready[0], out_valid[0], out_state[0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL rst_busy_no_valid: got out_valid high want low");
    end
    $display("rst_busy dut0 discarded block");
    run_block(0, V1, 1'b0, 1'b0, E1, 5, 0, "after_rst", got);
  endtask

  task automatic test_random();
    logic [127:0] st, fwd, got;
    logic         byp;
    int           d;
    for (int i = 0; i < 80; i++) begin
      d = i % 2;
      st = {$urandom, $urandom, $urandom, $urandom};
      byp = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if (byp) begin
        run_block(d, st, 1'($urandom_range(0, 1)), 1'b1, st, 1,
                  $urandom_range(0, 3), "rnd_byp", got);
      end else begin
        fwd = model_mix(st, 1'b0);
        run_block(d, st, 1'b0, 1'b0, fwd, (d == 0) ? 5 : 2,
                  $urandom_range(0, 3), "rnd_fwd", got);
        run_block(d, got, 1'b1, 1'b0, st, (d == 0) ? 5 : 2,
                  $urandom_range(0, 3), "rnd_rt", got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_bypass();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
